// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// using one full-subtractor cell with a registered borrow loop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, diff_nx;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             x, y, cell_d, cell_b, last, accept;

  // Full-subtractor cell and shift/accept decode
  always_comb begin
    x       = a_sh[0];
    y       = b_sh[0];
    cell_d  = x ^ y ^ brw;
    cell_b  = (~x & y) | (~(x ^ y) & brw);
    diff_nx = WIDTH'({cell_d, diff} >> 1);
    last    = (cnt == LAST);
    accept  = start && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SHIFT);
      done  <= (state_nx == DONE);
    end
  end

  // Operands are captured on accept so later input changes cannot disturb the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh       <= a;
      b_sh       <= b;
      brw        <= bin;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      brw  <= cell_b;
      cnt  <= cnt + CW'(1);
      diff <= diff_nx;
      if (last) borrow_out <= cell_b;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand-written
// handshake corner cases, random operands, and a WIDTH=1 exhaustive sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy, done, borrow_out;
  logic [7:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[6];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic, borrow means the true result went negative
  function automatic void model(input int width, input longint av, input longint bv, input bit binv,
                                output logic [7:0] d, output bit br);
    longint r;
    r  = av - bv - longint'(binv);
    br = (r < 0);
    r  = r & ((64'd1 << width) - 1);
    d  = r[7:0];
  endfunction

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input bit binv);
    a = av; b = bv; bin = binv; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~binv;
  endtask

  task automatic runOp(input logic [7:0] av, input logic [7:0] bv, input bit binv,
                       input logic [7:0] ed, input bit eb, input string tag);
    int lat, busy_cnt;
    applyStimulus(av, bv, binv);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, lat, 9);
    checkOutput({tag, " busy cycles"}, busy_cnt, 8);
    checkOutput({tag, " diff"}, diff, ed);
    checkOutput({tag, " borrow"}, borrow_out, eb);
    tick();
    checkOutput({tag, " done pulse width"}, done, 0);
    checkOutput({tag, " diff held"}, diff, ed);
  endtask

  initial begin
    logic [7:0] ed, ra, rb;
    bit         eb, rbin;
    int         done_cnt, lat;
    int         done_cyc[2];
    logic [7:0] done_diff[2];
    logic       done_brw[2];

    vecs[0] = '{8'd100, 8'd37,  1'b0, 8'h3F, 1'b0};
    vecs[1] = '{8'd37,  8'd100, 1'b0, 8'hC1, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF,  8'hFF,  1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'd10,  8'd3,   1'b0, 8'h07, 1'b0};
    vecs[5] = '{8'd3,   8'd10,  1'b0, 8'hF9, 1'b1};

    #12;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset diff", diff, 0);
    checkOutput("reset borrow", borrow_out, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      runOp(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_borrow, $sformatf("vec%0d", i));

    // Start pulse during SHIFT must be ignored
    applyStimulus(8'd50, 8'd20, 1'b0);
    tick(); tick();
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        done_cnt++;
        checkOutput("ignored-start diff", diff, 30);
        checkOutput("ignored-start borrow", borrow_out, 0);
      end
      tick();
    end
    checkOutput("ignored-start done count", done_cnt, 1);

    // Asynchronous reset in the middle of an operation
    applyStimulus(8'd100, 8'd37, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset diff", diff, 0);
    checkOutput("midreset borrow", borrow_out, 0);
    #2;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_cnt++;
      tick();
    end
    checkOutput("midreset no done", done_cnt, 0);
    runOp(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, "after-reset");

    // start held high: back-to-back accepts through DONE
    a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
    tick();
    a = 8'd3; b = 8'd10;
    done_cnt = 0;
    for (int i = 0; i < 40 && done_cnt < 2; i++) begin
      if (done) begin
        done_cyc[done_cnt]  = cyc;
        done_diff[done_cnt] = diff;
        done_brw[done_cnt]  = borrow_out;
        done_cnt++;
      end
      if (done_cnt < 2) tick();
    end
    start = 1'b0;
    checkOutput("held-start done count", done_cnt, 2);
    if (done_cnt == 2) begin
      checkOutput("held-start first diff", done_diff[0], 8'h07);
      checkOutput("held-start first borrow", done_brw[0], 0);
      checkOutput("held-start second diff", done_diff[1], 8'hF9);
      checkOutput("held-start second borrow", done_brw[1], 1);
      checkOutput("held-start spacing", done_cyc[1] - done_cyc[0], 9);
    end
    tick(); tick();

    // Random operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      model(8, longint'(ra), longint'(rb), rbin, ed, eb);
      runOp(ra, rb, rbin, ed, eb, $sformatf("rand%0d", i));
    end

    // WIDTH=1 exhaustive sweep
    for (int v = 0; v < 8; v++) begin
      a1 = 1'(v >> 2); b1 = 1'(v >> 1); bin1 = 1'(v);
      model(1, longint'(a1), longint'(b1), bin1, ed, eb);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 6) begin
        tick();
        lat++;
      end
      checkOutput($sformatf("w1 case%0d latency", v), lat, 2);
      checkOutput($sformatf("w1 case%0d diff", v), diff1, ed[0]);
      checkOutput($sformatf("w1 case%0d borrow", v), borrow1, eb);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial multi-bit subtractor. Computes diff = a - b - bin over WIDTH bits, LSB first, one bit per clock.
- Built around a single 1-bit full-subtractor cell: diff = x^y^c, borrow = (~x&y) | (~(x^y)&c).
- The cell's borrow output is registered and fed back as its borrow input on the next cycle.
- Area-lean alternative to a ripple subtractor for wide, non-time-critical datapaths; start/busy/done handshake to the controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when state is IDLE or DONE
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- bin  input  1  initial borrow-in; captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result becomes valid
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH; held until next accepted start
- borrow_out  output  1  final borrow (1 means a < b + bin); held with diff

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers=0, borrow flop=0, bit counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: latch a, b into shift registers; load borrow flop with bin; counter=0; clear diff and borrow_out; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, at each edge:
  - Cell inputs: x = a_sh[0], y = b_sh[0], c = borrow flop.
  - Shift cell diff into diff[WIDTH-1]; shift diff, a_sh and b_sh right by one.
  - Load borrow flop with cell borrow; counter += 1.
  - When the edge processes bit WIDTH-1: diff holds the full result, borrow_out takes the cell borrow, go to DONE.
  - start is ignored in SHIFT.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1: same action as IDLE start (back-to-back operation), go to SHIFT.
  - Otherwise go to IDLE.
- busy: registered, equal to (state==SHIFT).
- Timing: start accepted at edge k. busy high from k to k+WIDTH. done high from k+WIDTH to k+WIDTH+1. Latency = WIDTH+1 edges from start edge to done deassert; throughput = one result per WIDTH+1 cycles.
- diff during SHIFT is partial and must not be consumed. diff/borrow_out are valid from the done cycle until the next accepted start.
- Arithmetic:
  - Result is modular, no saturation.
  - borrow_out is the unsigned-underflow flag.
  - Two's-complement overflow is not reported.
- Counter: $clog2(WIDTH+1) bits. It must not wrap before reaching WIDTH-1; a WIDTH=1 build completes in one SHIFT edge.
- Inputs a, b, bin may change freely after the accepted start edge without affecting the operation in flight.
- Reset mid-operation: asynchronous return to IDLE, all outputs to reset values, no done pulse. The in-flight operation is discarded.
- start held high continuously: one operation per WIDTH+1 cycles, via the DONE->SHIFT path.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0 -> done exactly 9 edges after start edge; diff=63 (0x3F), borrow_out=0; busy high 8 cycles.
- WIDTH=8, a=37, b=100, bin=0 -> diff=0xC1 (193), borrow_out=1.
- WIDTH=8, a=0, b=0, bin=1 -> diff=0xFF, borrow_out=1. With a=0xFF, b=0xFF, bin=0 -> diff=0x00, borrow_out=0.
- Start a=50, b=20; pulse start with a=1, b=2 at cycle 3 of SHIFT -> ignored; result diff=30, borrow_out=0; only one done pulse.
- Assert rst_n=0 at SHIFT cycle 4 -> busy, done, diff, borrow_out go to 0 immediately, no done pulse. A new start after release gives the correct result.
- Hold start=1 with a=10, b=3 then a=3, b=10 on consecutive accepts -> done pulses 9 cycles apart with diff=7/borrow 0, then diff=0xF9/borrow 1. Add WIDTH=1 exhaustive sweep of a, b, bin (8 cases) against a 1-bit full-subtractor truth table.
